mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Parametrised, clocked successor to the Y86-64 pipeline memory stage. Sits between the M pipeline register and the W stage.
- Performs data-memory reads and writes with a configurable multi-cycle latency, byte addressing and bounds checking.
- Adds a ready/valid handshake so hazard control can stall the upstream stages.
- Holds a sticky halt state: once an exception status has been emitted, the architectural memory state is frozen.

Parameters:
- DATA_W, 64, word width in bits; also the width of valE, valA and valM.
- DEPTH, 2048, number of DATA_W-bit words; the legal byte range is [0, DEPTH*DATA_W/8).
- MEM_LAT, 2, cycles from acceptance to completion for a memory access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- M_valid  in  1  M register holds a real instruction, not a bubble
- M_stat  in  4  one-hot status: bit0 AOK, bit1 HLT, bit2 INS, bit3 ADR
- M_icode  in  4  instruction code
- M_cnd  in  1  condition flag from the execute stage
- M_valE  in  DATA_W  ALU result / effective address
- M_valA  in  DATA_W  store data, or the address used by ret and popq
- M_dstE, M_dstM  in  4  destination registers; 4'hF means none
- m_ready  out  1  stage can accept an instruction this cycle
- m_valid  out  1  outputs carry a completed instruction; one-cycle pulse per instruction
- m_stat, m_icode, m_dstE, m_dstM, m_cnd  out  4/4/4/4/1  registered pass-through, with m_stat modified as below
- m_valE, m_valM  out  DATA_W  registered valE, and the loaded value or pass-through value

Behaviour:
- Reset:
  - Asynchronous to the FSM, outputs, counter and halt flag.
  - m_valid=0, m_ready=1, all other outputs 0, state IDLE, halted=0.
  - Array contents are not reset.
- Accept: an instruction is accepted on a rising edge where M_valid && m_ready.
- Access class:
  - Write: icode 4, 8, 10; address valE.
  - Read: icode 5; address valE.
  - Read: icode 9, 11; address valA.
  - All other icodes: no access.
- Address check:
  - Word index is addr >> log2(DATA_W/8).
  - Out of range when addr >= DEPTH*DATA_W/8; the address is treated as unsigned.
- Exception and no-access path, 1-cycle latency (m_valid at the edge after acceptance, state stays IDLE):
  - M_stat != AOK: no access; m_stat = M_stat.
  - Access with an out-of-range address: no access; m_stat = 4'b1000.
  - No-access icode: m_valM = valA for icode 2, 3, 6, 7, else 0.
- Memory path:
  - IDLE goes to BUSY on acceptance; the counter loads MEM_LAT-1.
  - With MEM_LAT=1, BUSY is skipped and completion occurs at the next edge.
  - In BUSY: m_ready=0; the counter decrements each cycle; completion occurs at the edge where the counter is 0, then the FSM returns to IDLE.
  - Total latency from acceptance to m_valid is MEM_LAT cycles.
  - Request fields are captured at acceptance; M_* changes during BUSY are ignored.
- Completion: a write commits to the array on the completion edge; a read returns the array contents at that edge in m_valM.
  - A read accepted in the cycle after a write completes observes the new data.
- Halt:
  - halted is set on the edge where m_valid=1 and m_stat != AOK.
  - While halted: accepted instructions produce no access, m_valid stays 0, and m_ready remains 1 so upstream drains.
  - Only rst clears halted.
- Reset during BUSY: the access is abandoned, no write commits, and m_valid is not produced.
- m_valid is 0 in every cycle without a completion; the other outputs hold their last values.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an access whose address has any nonzero low log2(DATA_W/8) bits is flagged ADR. It takes the 1-cycle path, performs no access, and m_stat = 4'b1000.
- Undefined: the low bits are ignored and the access uses the truncated word index.

Decomposition:
- Package y86_pkg:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - Stat one-hot constants: SAOK, SHLT, SINS, SADR.
  - RNONE=4'hF.
  - FSM state typedef: IDLE, BUSY.
- Sub-module dmem_array: DEPTH x DATA_W, single port, synchronous write enable, combinational read sampled at completion. Keeps storage separate from control.

Test Plan:
- irmovq (icode 3), valE=5, valA=7 → m_valid one cycle later, m_valE=5, m_valM=7, m_stat=AOK, m_ready never low.
- rmmovq valE=0x10, valA=0xDEAD, MEM_LAT=2 → m_ready low 1 cycle, m_valid at +2; then mrmovq valE=0x10 → m_valM=0xDEAD at +2.
- popq valA=0x4000 (DEPTH=2048) → m_stat=4'b1000 at +1, no write; then rmmovq valE=0x18 → m_valid stays 0, and a later read after reset shows word 3 unwritten.
- M_stat=HLT with rmmovq valE=0x20 → m_stat=HLT at +1, word 4 unchanged, halted asserted; subsequent instructions produce no m_valid.
- rst asserted mid-BUSY of rmmovq valE=0x08, valA=1 → outputs 0 immediately, m_valid never pulses, word 1 retains its prior value.
- rmmovq valE=0x13 → with MEM_ALIGN_CHECK_EN: m_stat=4'b1000 at +1, no write; without it: word 2 written at +MEM_LAT.

Source files
------------

// File: rtl/mem_stage_mc_pkg.sv
// Y86-64 constants shared by the clocked memory stage: icodes, one-hot
// status codes, FSM state and access classification helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'b0001;
  localparam logic [3:0] SHLT = 4'b0010;
  localparam logic [3:0] SINS = 4'b0100;
  localparam logic [3:0] SADR = 4'b1000;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {IDLE, BUSY} state_t;

  // Memory access kind: none, read at valE, read at valA, write at valE.
  typedef enum logic [1:0] {ACC_NONE, ACC_RD_E, ACC_RD_A, ACC_WR} acc_t;

  function automatic acc_t acc_class(input logic [3:0] icode);
    case (icode)
      IRMMOVQ, ICALL, IPUSHQ: acc_class = ACC_WR;
      IMRMOVQ:                acc_class = ACC_RD_E;
      IRET, IPOPQ:            acc_class = ACC_RD_A;
      default:                acc_class = ACC_NONE;
    endcase
  endfunction

  // Instructions whose valM slot carries valA through to write-back.
  function automatic logic passes_valA(input logic [3:0] icode);
    passes_valA = (icode == IRRMOVQ) || (icode == IIRMOVQ) ||
                  (icode == IOPQ)    || (icode == IJXX);
  endfunction

endpackage

// File: rtl/mem_stage_mc_if.sv
// M-register to W-stage bundle of the memory stage. The master side is the
// upstream pipeline (drives M_*), the slave side is the memory stage.
interface mem_stage_mc_if #(
  parameter int DATA_W = 64
);
  logic              M_valid;
  logic [3:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;

  logic              m_ready;
  logic              m_valid;
  logic [3:0]        m_stat;
  logic [3:0]        m_icode;
  logic [3:0]        m_dstE;
  logic [3:0]        m_dstM;
  logic              m_cnd;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valM;

  modport master (
    output M_valid, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  m_ready, m_valid, m_stat, m_icode, m_dstE, m_dstM, m_cnd, m_valE, m_valM
  );

  modport slave (
    input  M_valid, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    output m_ready, m_valid, m_stat, m_icode, m_dstE, m_dstM, m_cnd, m_valE, m_valM
  );
endinterface

// File: rtl/mem_stage_mc_dmem.sv
// Data memory storage: DEPTH x DATA_W, single port, synchronous write,
// combinational read. Not reset; contents survive rst.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port commits on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage_mc.sv
// Clocked Y86-64 memory stage with MEM_LAT-cycle accesses, bounds checking,
// ready/valid handshake and a sticky halt once an exception is emitted.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses are flagged ADR.
module mem_stage_mc
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2048,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_stage_mc_if.slave bus
);
  localparam int                BPW      = DATA_W / 8;
  localparam int                OFF      = $clog2(BPW);
  localparam int                AW       = $clog2(DEPTH);
  localparam logic [DATA_W:0]   LIMIT    = (DATA_W+1)'(DEPTH * BPW);
  localparam logic [3:0]        CNT_LOAD = 4'(MEM_LAT - 1);
  localparam bit                LAT1     = (MEM_LAT == 1);

  state_t            r_state;
  logic              r_ready, r_valid, r_halted, r_cnd;
  logic [3:0]        r_cnt, r_stat, r_icode, r_dstE, r_dstM;
  logic [DATA_W-1:0] r_valE, r_valM;

  // Request captured at acceptance, used while BUSY.
  logic [3:0]        r_q_icode, r_q_dstE, r_q_dstM;
  logic              r_q_cnd, r_q_wr;
  logic [DATA_W-1:0] r_q_valE, r_q_valA;
  logic [AW-1:0]     r_q_widx;

  acc_t              w_acc;
  logic [DATA_W-1:0] w_addr, w_fast_valM, w_c_valE, w_wdata, w_rdata;
  logic              w_oor, w_mis, w_fast, w_accept, w_mem_go, w_done, w_we;
  logic              w_c_cnd, w_c_wr;
  logic [3:0]        w_fast_stat, w_c_icode, w_c_dstE, w_c_dstM;
  logic [AW-1:0]     w_widx, w_arr_idx;

  // Classify the incoming request and select the live or captured request.
  always_comb begin
    w_acc  = acc_class(bus.M_icode);
    w_addr = (w_acc == ACC_RD_A) ? bus.M_valA : bus.M_valE;
    w_oor  = (w_acc != ACC_NONE) && ({1'b0, w_addr} >= LIMIT);
`ifdef MEM_ALIGN_CHECK_EN
    w_mis  = (w_acc != ACC_NONE) && (|w_addr[OFF-1:0]);
`else
    w_mis  = 1'b0;
`endif
    w_widx      = w_addr[OFF +: AW];
    w_accept    = bus.M_valid && r_ready;
    w_fast      = (bus.M_stat != SAOK) || (w_acc == ACC_NONE) || w_oor || w_mis;
    w_fast_stat = (bus.M_stat != SAOK) ? bus.M_stat : ((w_oor || w_mis) ? SADR : SAOK);
    w_fast_valM = passes_valA(bus.M_icode) ? bus.M_valA : '0;
    w_mem_go    = w_accept && !r_halted && !w_fast && (r_state == IDLE);

    // The counter is loaded with MEM_LAT-1; the access completes on the edge
    // that takes it to zero. With MEM_LAT=1 it completes at acceptance.
    w_done    = ((r_state == BUSY) && (r_cnt == 4'd1)) || (w_mem_go && LAT1);

    w_c_icode = (r_state == BUSY) ? r_q_icode : bus.M_icode;
    w_c_dstE  = (r_state == BUSY) ? r_q_dstE  : bus.M_dstE;
    w_c_dstM  = (r_state == BUSY) ? r_q_dstM  : bus.M_dstM;
    w_c_cnd   = (r_state == BUSY) ? r_q_cnd   : bus.M_cnd;
    w_c_valE  = (r_state == BUSY) ? r_q_valE  : bus.M_valE;
    w_c_wr    = (r_state == BUSY) ? r_q_wr    : (w_acc == ACC_WR);
    w_arr_idx = (r_state == BUSY) ? r_q_widx  : w_widx;
    w_wdata   = (r_state == BUSY) ? r_q_valA  : bus.M_valA;
    w_we      = w_done && w_c_wr;
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_arr_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Capture the request fields of an accepted memory access.
  always_ff @(posedge clk) begin
    if (w_mem_go) begin
      r_q_icode <= bus.M_icode;
      r_q_dstE  <= bus.M_dstE;
      r_q_dstM  <= bus.M_dstM;
      r_q_cnd   <= bus.M_cnd;
      r_q_valE  <= bus.M_valE;
      r_q_valA  <= bus.M_valA;
      r_q_widx  <= w_widx;
      r_q_wr    <= (w_acc == ACC_WR);
    end
  end

  // Control FSM, registered outputs and sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
      r_stat   <= '0;
      r_icode  <= '0;
      r_dstE   <= '0;
      r_dstM   <= '0;
      r_cnd    <= 1'b0;
      r_valE   <= '0;
      r_valM   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && !r_halted && w_fast) begin
            r_valid <= 1'b1;
            r_stat  <= w_fast_stat;
            r_icode <= bus.M_icode;
            r_dstE  <= bus.M_dstE;
            r_dstM  <= bus.M_dstM;
            r_cnd   <= bus.M_cnd;
            r_valE  <= bus.M_valE;
            r_valM  <= w_fast_valM;
            if (w_fast_stat != SAOK) r_halted <= 1'b1;
          end else if (w_mem_go && !LAT1) begin
            r_state <= BUSY;
            r_ready <= 1'b0;
            r_cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_done) begin
        r_valid <= 1'b1;
        r_stat  <= SAOK;
        r_icode <= w_c_icode;
        r_dstE  <= w_c_dstE;
        r_dstM  <= w_c_dstM;
        r_cnd   <= w_c_cnd;
        r_valE  <= w_c_valE;
        r_valM  <= w_c_wr ? '0 : w_rdata;
      end
    end
  end

  assign bus.m_ready = r_ready;
  assign bus.m_valid = r_valid;
  assign bus.m_stat  = r_stat;
  assign bus.m_icode = r_icode;
  assign bus.m_dstE  = r_dstE;
  assign bus.m_dstM  = r_dstM;
  assign bus.m_cnd   = r_cnd;
  assign bus.m_valE  = r_valE;
  assign bus.m_valM  = r_valM;
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc (DATA_W=64, DEPTH=2048, MEM_LAT=2).
module tb_mem_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic        got;
  logic [3:0]  cap_stat, cap_icode, cap_dstE;
  logic [63:0] cap_valE, cap_valM;
  int          lat, rlow, seen;

  always #5 clk = ~clk;

  mem_stage_mc_if #(.DATA_W(64)) ifc ();

  mem_stage_mc #(
    .DATA_W  (64),
    .DEPTH   (2048),
    .MEM_LAT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one instruction for one cycle, then wait (bounded) for m_valid.
  task automatic run(input logic [3:0] icode, input logic [3:0] stat,
                     input logic [63:0] vale, input logic [63:0] vala);
    @(negedge clk);
    ifc.M_valid = 1'b1; ifc.M_icode = icode; ifc.M_stat = stat;
    ifc.M_valE = vale; ifc.M_valA = vala; ifc.M_cnd = 1'b1;
    ifc.M_dstE = 4'h2; ifc.M_dstM = 4'h3;
    lat = 0; rlow = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      ifc.M_valid = 1'b0;
      ifc.M_valE = 64'hFFFF_FFFF; ifc.M_valA = 64'hEEEE_EEEE;
      lat++;
      if (!ifc.m_ready) rlow++;
      if (ifc.m_valid) begin
        got = 1'b1;
        cap_stat = ifc.m_stat; cap_icode = ifc.m_icode; cap_dstE = ifc.m_dstE;
        cap_valE = ifc.m_valE; cap_valM = ifc.m_valM;
      end
    end
    if (got) begin
      @(negedge clk);
      chk("vld_pulse", 64'(ifc.m_valid), 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    ifc.M_valid = 1'b0; ifc.M_stat = 4'b0001; ifc.M_icode = 4'h1; ifc.M_cnd = 1'b0;
    ifc.M_valE = '0; ifc.M_valA = '0; ifc.M_dstE = 4'hF; ifc.M_dstM = 4'hF;

    @(negedge clk);
    chk("rst_valid", 64'(ifc.m_valid), 64'd0);
    chk("rst_ready", 64'(ifc.m_ready), 64'd1);
    chk("rst_stat",  64'(ifc.m_stat),  64'd0);
    chk("rst_valM",  ifc.m_valM,       64'd0);
    rst = 1'b0;

    // irmovq: one-cycle pass-through
    run(4'h3, 4'b0001, 64'd5, 64'd7);
    chk("irm_got",  64'(got), 64'd1);
    chk("irm_lat",  64'(lat), 64'd1);
    chk("irm_rlow", 64'(rlow), 64'd0);
    chk("irm_valE", cap_valE, 64'd5);
    chk("irm_valM", cap_valM, 64'd7);
    chk("irm_stat", 64'(cap_stat), 64'b0001);
    chk("irm_icode", 64'(cap_icode), 64'h3);
    chk("irm_dstE", 64'(cap_dstE), 64'h2);

    // rmmovq then mrmovq at 0x10
    run(4'h4, 4'b0001, 64'h10, 64'hDEAD);
    chk("wr_lat",  64'(lat), 64'd2);
    chk("wr_rlow", 64'(rlow), 64'd1);
    chk("wr_stat", 64'(cap_stat), 64'b0001);
    run(4'h5, 4'b0001, 64'h10, 64'h0);
    chk("rd_lat",  64'(lat), 64'd2);
    chk("rd_valM", cap_valM, 64'hDEAD);

    // preload words 1, 3, 4
    run(4'h4, 4'b0001, 64'h08, 64'h1111);
    run(4'h4, 4'b0001, 64'h18, 64'h3333);
    run(4'h4, 4'b0001, 64'h20, 64'h4444);

    // call writes at valE, ret reads at valA
    run(4'h8, 4'b0001, 64'h28, 64'h5555);
    chk("call_lat", 64'(lat), 64'd2);
    run(4'h9, 4'b0001, 64'h30, 64'h28);
    chk("ret_valM", cap_valM, 64'h5555);
    chk("ret_valE", cap_valE, 64'h30);

    // nop: no access, valM zero
    run(4'h1, 4'b0001, 64'h1, 64'h9);
    chk("nop_lat",  64'(lat), 64'd1);
    chk("nop_valM", cap_valM, 64'd0);

    // last legal word
    run(4'h4, 4'b0001, 64'h3FF8, 64'h77);
    run(4'h5, 4'b0001, 64'h3FF8, 64'h0);
    chk("top_valM", cap_valM, 64'h77);

    // misaligned store to 0x13
    run(4'h4, 4'b0001, 64'h13, 64'hBEEF);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_lat",  64'(lat), 64'd1);
    chk("mis_stat", 64'(cap_stat), 64'b1000);
    do_reset();
    run(4'h5, 4'b0001, 64'h10, 64'h0);
    chk("mis_word2", cap_valM, 64'hDEAD);
`else
    chk("mis_lat",  64'(lat), 64'd2);
    chk("mis_stat", 64'(cap_stat), 64'b0001);
    run(4'h5, 4'b0001, 64'h10, 64'h0);
    chk("mis_word2", cap_valM, 64'hBEEF);
`endif

    // popq out of range: ADR, then halted
    run(4'hB, 4'b0001, 64'h0, 64'h4000);
    chk("pop_lat",  64'(lat), 64'd1);
    chk("pop_stat", 64'(cap_stat), 64'b1000);
    run(4'h4, 4'b0001, 64'h18, 64'h9999);
    chk("halt_novld", 64'(got), 64'd0);
    chk("halt_ready", 64'(rlow), 64'd0);
    do_reset();
    run(4'h5, 4'b0001, 64'h18, 64'h0);
    chk("w3_kept", cap_valM, 64'h3333);

    // HLT status on a store
    run(4'h4, 4'b0010, 64'h20, 64'hAAAA);
    chk("hlt_lat",  64'(lat), 64'd1);
    chk("hlt_stat", 64'(cap_stat), 64'b0010);
    run(4'h3, 4'b0001, 64'h1, 64'h2);
    chk("hlt_novld", 64'(got), 64'd0);
    do_reset();
    run(4'h5, 4'b0001, 64'h20, 64'h0);
    chk("w4_kept", cap_valM, 64'h4444);

    // reset during BUSY
    @(negedge clk);
    ifc.M_valid = 1'b1; ifc.M_icode = 4'h4; ifc.M_stat = 4'b0001;
    ifc.M_valE = 64'h08; ifc.M_valA = 64'h1;
    @(negedge clk);
    ifc.M_valid = 1'b0;
    chk("busy_ready", 64'(ifc.m_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ifc.m_ready), 64'd1);
    chk("arst_valE",  ifc.m_valE, 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifc.m_valid) seen++;
    end
    chk("arst_novld", 64'(seen), 64'd0);
    run(4'h5, 4'b0001, 64'h08, 64'h0);
    chk("w1_kept", cap_valM, 64'h1111);

    // huge address is unsigned, so out of range
    run(4'h5, 4'b0001, 64'h8000_0000_0000_0010, 64'h0);
    chk("big_stat", 64'(cap_stat), 64'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
